// File: rtl/systolic_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// systolic_pkg : shared state and load-kind enums for the systolic sequencer
// Rev 1.0
// ============================================================================
package systolic_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        WEIGHT  = 2'd1,
        PARTIAL = 2'd2,
        INPUT   = 2'd3
    } load_kind_t;

endpackage
`default_nettype wire

// File: rtl/systolic_skew_gen.sv
`default_nettype none
// ============================================================================
// systolic_skew_gen : decodes the pass counter into diagonal FIFO shifts and
//                     the output-row window
// Rev 1.0
// ============================================================================
module systolic_skew_gen #(
    parameter  int ARRAY_DIM = 4,
    localparam int RW        = $clog2(ARRAY_DIM),
    localparam int CW        = $clog2(3 * ARRAY_DIM)
) (
    input  logic                 run,
    input  logic [CW-1:0]        c,
    output logic [ARRAY_DIM-1:0] fifo_shift,
    output logic [ARRAY_DIM-1:0] ps_fifo_shift,
    output logic [RW-1:0]        row_out,
    output logic                 out_valid
);

    localparam int            N           = ARRAY_DIM;
    localparam logic [CW-1:0] c_out_first = CW'(2 * N - 1);
    localparam logic [CW-1:0] c_out_last  = CW'(3 * N - 2);

    // Row r sees its inputs N cycles starting at c=r, partial sums N cycles later.
    for (genvar r = 0; r < N; r++) begin : g_row
        assign fifo_shift[r]    = run && (int'(c) >= r)     && (int'(c) < r + N);
        assign ps_fifo_shift[r] = run && (int'(c) >= r + N) && (int'(c) < r + 2 * N);
    end

    assign out_valid = run && (c >= c_out_first) && (c <= c_out_last);
    assign row_out   = out_valid ? RW'(c - c_out_first) : '0;

endmodule
`default_nettype wire

// File: rtl/systolic_sequencer.sv
`default_nettype none
// ============================================================================
// systolic_sequencer : weight-stationary systolic array load/compute sequencer
// Rev 1.0
// ============================================================================
module systolic_sequencer
    import systolic_pkg::*;
#(
    parameter  int ARRAY_DIM = 4,
    parameter  int DATA_W    = 16,
    localparam int RW        = $clog2(ARRAY_DIM),
    localparam int CW        = $clog2(3 * ARRAY_DIM)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 weight_en,
    input  logic                 input_en,
    input  logic                 partial_en,
    input  logic [RW-1:0]        row_en,
    input  logic                 start,
    output logic                 fifo_has_space,
    output logic                 weight_load,
    output logic                 input_load,
    output logic                 partials_load,
    output logic [RW-1:0]        weight_row,
    output logic [RW-1:0]        input_row,
    output logic [RW-1:0]        partials_row,
    output logic                 MAC_start,
    output logic                 MAC_count,
    output logic [ARRAY_DIM-1:0] fifo_shift,
    output logic [ARRAY_DIM-1:0] ps_fifo_shift,
    output logic [RW-1:0]        row_out,
    output logic                 out_valid,
    output logic                 busy
);

    localparam int               N            = ARRAY_DIM;
    localparam int               CNT_W        = RW + 1;
    localparam logic [CW-1:0]    c_last       = CW'(3 * N - 2);
    localparam logic [CNT_W-1:0] c_fifo_depth = CNT_W'(N);

    if (ARRAY_DIM < 2 || ARRAY_DIM > 16 || (ARRAY_DIM & (ARRAY_DIM - 1)) != 0 || DATA_W < 1)
    begin : g_param_check
        $error("systolic_sequencer: unsupported ARRAY_DIM or DATA_W");
    end

    seq_state_t       r_state;
    seq_state_t       w_state_next;
    load_kind_t       w_kind;
    logic [CW-1:0]    r_c;
    logic [N-1:0]     r_mask;
    logic [CNT_W-1:0] r_count [N];
    logic             w_idle;
    logic             w_run;
    logic             w_last;
    logic             w_start_ok;
    logic             r_weight_load;
    logic             r_input_load;
    logic             r_partials_load;
    logic [RW-1:0]    r_weight_row;
    logic [RW-1:0]    r_input_row;
    logic [RW-1:0]    r_partials_row;

    assign w_idle         = (r_state == IDLE);
    assign w_run          = (r_state == RUN);
    assign w_last         = w_run && (r_c == c_last);
    // Start qualifies on the mask as registered, not on a weight beat arriving now.
    assign w_start_ok     = w_idle && start && (&r_mask);
    assign fifo_has_space = w_idle && (r_count[row_en] < c_fifo_depth);

    always_comb begin
        w_kind = NONE;
        if (w_idle) begin
            if (weight_en)                         w_kind = WEIGHT;
            else if (partial_en)                   w_kind = PARTIAL;
            else if (input_en && fifo_has_space)   w_kind = INPUT;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_state_next = RUN;
            RUN:     if (w_last)     w_state_next = IDLE;
            default:                 w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                  r_c <= '0;
        else if (w_run && !w_last)  r_c <= r_c + 1'b1;
        else                        r_c <= '0;
    end

    // Weights stay stationary across passes; input counts empty with each pass.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_mask <= '0;
            for (int i = 0; i < N; i++) r_count[i] <= '0;
        end else begin
            if (w_kind == WEIGHT) r_mask[row_en] <= 1'b1;
            if (w_last) begin
                for (int i = 0; i < N; i++) r_count[i] <= '0;
            end else if (w_kind == INPUT) begin
                r_count[row_en] <= r_count[row_en] + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_weight_load   <= 1'b0;
            r_input_load    <= 1'b0;
            r_partials_load <= 1'b0;
            r_weight_row    <= '0;
            r_input_row     <= '0;
            r_partials_row  <= '0;
        end else begin
            r_weight_load   <= (w_kind == WEIGHT);
            r_input_load    <= (w_kind == INPUT);
            r_partials_load <= (w_kind == PARTIAL);
            if (w_kind == WEIGHT)  r_weight_row   <= row_en;
            if (w_kind == INPUT)   r_input_row    <= row_en;
            if (w_kind == PARTIAL) r_partials_row <= row_en;
        end
    end

    assign weight_load   = r_weight_load;
    assign input_load    = r_input_load;
    assign partials_load = r_partials_load;
    assign weight_row    = r_weight_row;
    assign input_row     = r_input_row;
    assign partials_row  = r_partials_row;
    assign MAC_start     = w_run && (r_c == '0);
    assign MAC_count     = w_run;
    assign busy          = w_run;

    systolic_skew_gen #(
        .ARRAY_DIM (ARRAY_DIM)
    ) u_skew_gen (
        .run           (w_run),
        .c             (r_c),
        .fifo_shift    (fifo_shift),
        .ps_fifo_shift (ps_fifo_shift),
        .row_out       (row_out),
        .out_valid     (out_valid)
    );

endmodule
`default_nettype wire
